// File: rtl/uart_rx_ctrl.sv
// ============================================================================
// Module      : uart_rx_ctrl
// Description : UART receive controller: 16x baud-tick generator, byte-ready
//               acknowledge handshake and show-ahead receive FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx_ctrl #(
    parameter int DIV_DEFAULT = 27,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                          clock50,
    input  logic                          reset,
    input  logic                          enable,
    input  logic                          cfg_we,
    input  logic [15:0]                   cfg_div,
    output logic                          rx_tick,
    input  logic                          rx_rdy,
    input  logic [7:0]                    rx_data,
    output logic                          rx_clear,
    input  logic                          rd_en,
    output logic [7:0]                    rd_data,
    output logic                          rd_valid,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          overflow,
    input  logic                          ovf_clr
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACK  = 2'd1,
        WAIT = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Baud-tick generator
    // ------------------------------------------------------------------
    logic [15:0] r_div;
    logic [15:0] r_tick_cnt;
    logic [15:0] w_div_eff;
    logic        w_tick_wrap;

    // A divisor of zero behaves as one, giving a continuous tick.
    assign w_div_eff   = (r_div == 16'd0) ? 16'd1 : r_div;
    assign w_tick_wrap = (r_tick_cnt == (w_div_eff - 16'd1));

    always_ff @(posedge clock50) begin
        if (reset) begin
            r_div      <= 16'(DIV_DEFAULT);
            r_tick_cnt <= 16'd0;
            rx_tick    <= 1'b0;
        end else if (cfg_we) begin
            r_div      <= cfg_div;
            r_tick_cnt <= 16'd0;
            rx_tick    <= 1'b0;
        end else begin
            rx_tick <= enable & w_tick_wrap;
            if (enable) begin
                r_tick_cnt <= w_tick_wrap ? 16'd0 : (r_tick_cnt + 16'd1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Acknowledge handshake FSM
    // ------------------------------------------------------------------
    state_t r_state;
    state_t w_state_nxt;
    logic   w_push;

    always_ff @(posedge clock50) begin
        if (reset) begin
            r_state  <= IDLE;
            rx_clear <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            rx_clear <= w_push;
        end
    end

    // Capture happens only from IDLE so one rx_rdy assertion gives one push.
    always_comb begin
        w_state_nxt = r_state;
        w_push      = 1'b0;
        case (r_state)
            IDLE: begin
                if (rx_rdy) begin
                    w_push      = 1'b1;
                    w_state_nxt = ACK;
                end
            end
            ACK:     w_state_nxt = WAIT;
            WAIT:    if (!rx_rdy) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Receive FIFO
    // ------------------------------------------------------------------
    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic          w_full;
    logic          w_pop;
    logic          w_wr;

    assign w_full   = (count == CW'(FIFO_DEPTH));
    assign rd_valid = (count != '0);
    assign w_pop    = rd_en & rd_valid;
    // When full, a simultaneous pop frees the head slot that wr_ptr aliases.
    assign w_wr     = w_push & (~w_full | w_pop);
    assign rd_data  = r_mem[r_rd_ptr];

    always_ff @(posedge clock50) begin
        if (!reset && w_wr) begin
            r_mem[r_wr_ptr] <= rx_data;
        end
    end

    always_ff @(posedge clock50) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (w_wr)  r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_wr, w_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (w_push && w_full && !w_pop) begin
                overflow <= 1'b1;
            end else if (ovf_clr) begin
                overflow <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_ctrl.sv
// ============================================================================
// Module      : tb_uart_rx_ctrl
// Description : Directed self-checking bench for uart_rx_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_rx_ctrl;

    logic        clock50;
    logic        reset;
    logic        enable;
    logic        cfg_we;
    logic [15:0] cfg_div;
    logic        rx_tick;
    logic        rx_rdy;
    logic [7:0]  rx_data;
    logic        rx_clear;
    logic        rd_en;
    logic [7:0]  rd_data;
    logic        rd_valid;
    logic [2:0]  count;
    logic        overflow;
    logic        ovf_clr;

    int tests;
    int failed;

    uart_rx_ctrl #(
        .DIV_DEFAULT (27),
        .FIFO_DEPTH  (4)
    ) dut (
        .clock50  (clock50),
        .reset    (reset),
        .enable   (enable),
        .cfg_we   (cfg_we),
        .cfg_div  (cfg_div),
        .rx_tick  (rx_tick),
        .rx_rdy   (rx_rdy),
        .rx_data  (rx_data),
        .rx_clear (rx_clear),
        .rd_en    (rd_en),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .count    (count),
        .overflow (overflow),
        .ovf_clr  (ovf_clr)
    );

    initial clock50 = 1'b0;
    always #5 clock50 = ~clock50;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic step();
        @(negedge clock50);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    // Receiver side: present a byte, drop rx_rdy once rx_clear is seen.
    task automatic push_byte(input logic [7:0] b);
        rx_data = b;
        rx_rdy  = 1'b1;
        step();
        check("push_clear_hi", rx_clear, 1);
        rx_rdy = 1'b0;
        step();
        check("push_clear_lo", rx_clear, 0);
        step();
    endtask

    task automatic pop_expect(input logic [7:0] b);
        check("pop_valid", rd_valid, 1);
        check("pop_data", rd_data, b);
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
    endtask

    initial begin
        int n_ticks;
        int last;
        int clears;
        tests   = 0;
        failed  = 0;
        reset   = 1'b1;
        enable  = 1'b0;
        cfg_we  = 1'b0;
        cfg_div = 16'd0;
        rx_rdy  = 1'b0;
        rx_data = 8'h00;
        rd_en   = 1'b0;
        ovf_clr = 1'b0;
        step();
        step();

        // Reset state
        check("rst_tick", rx_tick, 0);
        check("rst_clear", rx_clear, 0);
        check("rst_count", count, 0);
        check("rst_valid", rd_valid, 0);
        check("rst_ovf", overflow, 0);

        // Default tick rate: 1000 cycles, divisor 27
        reset   = 1'b0;
        enable  = 1'b1;
        n_ticks = 0;
        last    = 0;
        for (int s = 1; s <= 1000; s++) begin
            step();
            if (rx_tick) begin
                n_ticks++;
                check("tick_gap", s - last, 27);
                last = s;
            end
        end
        check("tick_total", n_ticks, 37);

        // Reconfigure to 4 at cycle 10
        do_reset();
        for (int s = 1; s <= 10; s++) step();
        cfg_we  = 1'b1;
        cfg_div = 16'd4;
        step();
        cfg_we = 1'b0;
        check("cfg_no_tick_11", rx_tick, 0);
        for (int s = 12; s <= 26; s++) begin
            step();
            check("cfg_tick_seq", rx_tick, (s >= 15 && ((s - 15) % 4) == 0) ? 1 : 0);
        end
        // Counter is at div-1 here: the rewrite must suppress the pending tick
        cfg_we = 1'b1;
        step();
        cfg_we = 1'b0;
        check("cfg_suppress", rx_tick, 0);
        for (int s = 28; s <= 31; s++) begin
            step();
            check("cfg_tick_after", rx_tick, (s == 31) ? 1 : 0);
        end

        // Divisor 0 acts as 1: continuous tick
        cfg_we  = 1'b1;
        cfg_div = 16'd0;
        step();
        cfg_we = 1'b0;
        check("div0_first", rx_tick, 0);
        for (int s = 0; s < 5; s++) begin
            step();
            check("div0_cont", rx_tick, 1);
        end
        enable = 1'b0;
        step();
        check("disable_tick", rx_tick, 0);

        // Handshake with rx_rdy held several cycles
        do_reset();
        check("hs_pre_valid", rd_valid, 0);
        rx_data = 8'hA5;
        rx_rdy  = 1'b1;
        clears  = 0;
        for (int s = 0; s < 4; s++) begin
            step();
            if (s == 0) begin
                check("hs_valid", rd_valid, 1);
                check("hs_data", rd_data, 8'hA5);
            end
            if (rx_clear) clears++;
        end
        rx_rdy = 1'b0;
        for (int s = 0; s < 3; s++) begin
            step();
            if (rx_clear) clears++;
        end
        check("hs_clears", clears, 1);
        check("hs_count", count, 1);
        pop_expect(8'hA5);
        check("hs_empty", count, 0);

        // Overflow: 5 bytes into depth 4
        for (int b = 1; b <= 5; b++) push_byte(8'(b));
        check("ovf_count", count, 4);
        check("ovf_flag", overflow, 1);
        for (int b = 1; b <= 4; b++) pop_expect(8'(b));
        check("ovf_drained", count, 0);
        check("ovf_sticky", overflow, 1);
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        check("ovf_cleared", overflow, 0);

        // Pop while empty is ignored
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
        check("empty_pop_count", count, 0);
        check("empty_pop_valid", rd_valid, 0);
        push_byte(8'h77);
        pop_expect(8'h77);

        // Set wins over ovf_clr
        push_byte(8'h11);
        push_byte(8'h22);
        push_byte(8'h33);
        push_byte(8'h44);
        rx_data = 8'h99;
        rx_rdy  = 1'b1;
        ovf_clr = 1'b1;
        step();
        rx_rdy  = 1'b0;
        ovf_clr = 1'b0;
        check("set_wins", overflow, 1);
        check("set_wins_count", count, 4);
        step();
        step();
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        check("ovf_clr2", overflow, 0);

        // Full plus simultaneous push and pop
        rx_data = 8'h55;
        rx_rdy  = 1'b1;
        rd_en   = 1'b1;
        step();
        rx_rdy = 1'b0;
        rd_en  = 1'b0;
        check("full_sim_count", count, 4);
        check("full_sim_ovf", overflow, 0);
        check("full_sim_clear", rx_clear, 1);
        step();
        step();
        pop_expect(8'h22);
        pop_expect(8'h33);
        pop_expect(8'h44);
        pop_expect(8'h55);
        check("full_sim_empty", count, 0);

        // Reset during ACK with rx_rdy still high
        rx_data = 8'h3C;
        rx_rdy  = 1'b1;
        step();
        check("mid_capture", count, 1);
        reset = 1'b1;
        step();
        check("mid_rst_clear", rx_clear, 0);
        check("mid_rst_count", count, 0);
        check("mid_rst_valid", rd_valid, 0);
        check("mid_rst_ovf", overflow, 0);
        check("mid_rst_tick", rx_tick, 0);
        reset = 1'b0;
        step();
        check("recap_count", count, 1);
        check("recap_clear", rx_clear, 1);
        check("recap_data", rd_data, 8'h3C);
        rx_rdy = 1'b0;
        step();
        step();

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

`default_nettype wire
